// File: rtl/puf_scheduler.sv
// puf_scheduler
// Sequences one PUF response readout: captures a challenge seed, holds the
// PUF control FSM in start until it reports done (or a cycle budget runs
// out), gives it one idle cycle to return home, then shifts the response
// out of the PUF shift register eight bits at a time and offers each packed
// byte downstream on a valid/ready handshake.
//
// Ports
//   clk          single clock, rising edge
//   rst          asynchronous active-high reset
//   req          host run request (level, sampled only when idle)
//   seed[7:0]    challenge seed, captured on request acceptance
//   busy         high whenever a run or error is in progress
//   puf_seed     registered seed for the challenge LFSR
//   puf_start    level start to the PUF control FSM
//   puf_done     one-cycle completion pulse from the PUF control FSM
//   resp_bit     head bit of the PUF response shift register
//   resp_shift   shift enable to the PUF response shift register
//   byte_data    packed response byte, first bit received in the MSB
//   byte_valid   byte_data is valid and held until accepted
//   byte_ready   downstream accepts byte_data
//   resp_done    one-cycle pulse after the final byte is accepted
//   timeout_err  high while parked in the error state

module puf_scheduler #(
  parameter int NBYTES  = 32,
  parameter int TIMEOUT = 1048575
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [7:0] seed,
  output logic       busy,
  output logic [7:0] puf_seed,
  output logic       puf_start,
  input  logic       puf_done,
  input  logic       resp_bit,
  output logic       resp_shift,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       resp_done,
  output logic       timeout_err
);

  localparam int              BW        = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [19:0]     TMO_LAST  = 20'(TIMEOUT - 1);
  localparam logic [BW-1:0]   LAST_BYTE = BW'(NBYTES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    RELEASE = 3'd2,
    SHIFT   = 3'd3,
    PRESENT = 3'd4,
    ERR     = 3'd5
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [19:0]   tmo_cnt;
  logic [BW-1:0] byte_cnt;
  logic [2:0]    bit_cnt;
  logic          handshake;
  logic          last_accept;

  // byte_valid is only ever high in PRESENT, so a handshake seen here is
  // always a real transfer; ready while nothing is offered does nothing.
  always_comb begin
    handshake   = byte_valid & byte_ready;
    last_accept = 1'b0;
    state_nx    = IDLE;
    case (state)
      IDLE:    state_nx = req ? RUN : IDLE;
      // A done pulse arriving on the final budget cycle still counts as
      // success, so it is tested before the timeout.
      RUN: begin
        if (puf_done)
          state_nx = RELEASE;
        else if (tmo_cnt == TMO_LAST)
          state_nx = ERR;
        else
          state_nx = RUN;
      end
      RELEASE: state_nx = SHIFT;
      SHIFT:   state_nx = (bit_cnt == 3'd7) ? PRESENT : SHIFT;
      PRESENT: begin
        if (handshake) begin
          last_accept = (byte_cnt == LAST_BYTE);
          state_nx    = last_accept ? IDLE : SHIFT;
        end else begin
          state_nx = PRESENT;
        end
      end
      ERR:     state_nx = req ? ERR : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // Status outputs are registered from the next state so each one lines up
  // exactly with the state it describes, without any combinational path to
  // the ports. The byte register doubles as byte_data: it only moves while
  // shifting, so it is naturally frozen for the whole PRESENT phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy        <= 1'b0;
      puf_seed    <= 8'h00;
      puf_start   <= 1'b0;
      resp_shift  <= 1'b0;
      byte_data   <= 8'h00;
      byte_valid  <= 1'b0;
      resp_done   <= 1'b0;
      timeout_err <= 1'b0;
      tmo_cnt     <= 20'd0;
      byte_cnt    <= '0;
      bit_cnt     <= 3'd0;
    end else begin
      busy        <= (state_nx != IDLE);
      puf_start   <= (state_nx == RUN);
      resp_shift  <= (state_nx == SHIFT);
      byte_valid  <= (state_nx == PRESENT);
      timeout_err <= (state_nx == ERR);
      resp_done   <= last_accept;
      case (state)
        IDLE: begin
          bit_cnt <= 3'd0;
          if (req) begin
            puf_seed <= seed;
            tmo_cnt  <= 20'd0;
            byte_cnt <= '0;
          end
        end
        RUN:     tmo_cnt <= tmo_cnt + 20'd1;
        RELEASE: bit_cnt <= 3'd0;
        // bit_cnt wraps from 7 back to 0, ready for the next byte.
        SHIFT: begin
          byte_data <= {byte_data[6:0], resp_bit};
          bit_cnt   <= bit_cnt + 3'd1;
        end
        PRESENT: begin
          if (handshake && (byte_cnt != LAST_BYTE))
            byte_cnt <= byte_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_puf_scheduler.sv
// tb_puf_scheduler
// Drives directed runs through two scheduler instances: one with default
// parameters for the full 32-byte readout, backpressure and mid-run reset,
// and one with a 15-cycle budget and two bytes for the timeout behaviour.
// A behavioural response shift register feeds resp_bit; every byte the
// scheduler should produce is queued when its run starts and a separate
// monitor pops and compares on each accepted transfer.

module tb_puf_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic [7:0] seed;
  logic       busy;
  logic [7:0] puf_seed;
  logic       puf_start;
  logic       puf_done;
  logic       resp_bit;
  logic       resp_shift;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;
  logic       resp_done;
  logic       timeout_err;

  logic       t_req;
  logic [7:0] t_seed;
  logic       t_busy;
  logic [7:0] t_puf_seed;
  logic       t_puf_start;
  logic       t_puf_done;
  logic       t_resp_bit;
  logic       t_resp_shift;
  logic [7:0] t_byte_data;
  logic       t_byte_valid;
  logic       t_byte_ready;
  logic       t_resp_done;
  logic       t_timeout_err;

  logic [7:0] src_bytes [32];
  logic [7:0] src_idx;
  logic       src_clr;
  logic [7:0] exp_q [$];
  logic [7:0] exp_byte;

  int n_cmp = 0;
  int n_err = 0;
  int tot_shift = 0;
  int tot_done = 0;

  always #5 clk = ~clk;

  puf_scheduler dut (
    .clk(clk), .rst(rst), .req(req), .seed(seed), .busy(busy),
    .puf_seed(puf_seed), .puf_start(puf_start), .puf_done(puf_done),
    .resp_bit(resp_bit), .resp_shift(resp_shift), .byte_data(byte_data),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .resp_done(resp_done),
    .timeout_err(timeout_err)
  );

  puf_scheduler #(.NBYTES(2), .TIMEOUT(15)) dut_tmo (
    .clk(clk), .rst(rst), .req(t_req), .seed(t_seed), .busy(t_busy),
    .puf_seed(t_puf_seed), .puf_start(t_puf_start), .puf_done(t_puf_done),
    .resp_bit(t_resp_bit), .resp_shift(t_resp_shift), .byte_data(t_byte_data),
    .byte_valid(t_byte_valid), .byte_ready(t_byte_ready), .resp_done(t_resp_done),
    .timeout_err(t_timeout_err)
  );

  // Response shift register model: the head bit is the next bit of the
  // byte table, MSB first, advancing on every enabled shift.
  assign resp_bit = src_bytes[src_idx[7:3]][3'd7 - src_idx[2:0]];

  always @(posedge clk) begin
    if (src_clr)
      src_idx <= 8'd0;
    else if (resp_shift)
      src_idx <= src_idx + 8'd1;
  end

  // Running totals of shift cycles and done pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (resp_shift) tot_shift++;
    if (resp_done)  tot_done++;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Scoreboard monitor: looks just after the falling edge so the handshake
  // it sees is exactly the one the next rising edge will complete.
  always @(negedge clk) begin
    #1;
    if (byte_valid && byte_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_byte", int'(byte_data), -1);
      end else begin
        exp_byte = exp_q.pop_front();
        checkOutput("byte_data", int'(byte_data), int'(exp_byte));
      end
    end
  end

  // One full run on the main instance. done_delay: RUN cycles before the
  // done pulse; stall_byte: byte held back 50 cycles by byte_ready=0;
  // abort_byte: byte during whose shifting rst is asserted; rel_rst: release
  // rst together with the request; hold_req: keep req high (with a changed
  // seed) into RUN to show it is ignored there.
  task automatic applyStimulus(input logic [7:0] s, input int done_delay,
                               input int stall_byte, input int abort_byte,
                               input bit rel_rst, input bit hold_req);
    int start_len, sh, guard, stable, extra, shift_base, done_base;
    logic [7:0]  d0;
    logic [21:0] v;
    src_clr = 1'b1;
    @(negedge clk);
    src_clr    = 1'b0;
    shift_base = tot_shift;
    done_base  = tot_done;
    seed = s;
    req  = 1'b1;
    if (rel_rst) rst = 1'b0;
    @(negedge clk);
    checkOutput("accept_busy_start", int'({busy, puf_start}), 3);
    if (!hold_req) req = 1'b0;
    start_len = 0;
    guard     = 0;
    while (puf_start && guard < done_delay + 50) begin
      start_len++;
      guard++;
      if (hold_req && start_len == 1) seed = 8'h3C;
      if (hold_req && start_len == 5) req = 1'b0;
      if (start_len == done_delay) begin
        puf_done = 1'b1;
        @(negedge clk);
        puf_done = 1'b0;
        break;
      end
      @(negedge clk);
    end
    checkOutput("puf_start_len", start_len, done_delay);
    checkOutput("release_state", int'({busy, puf_start, resp_shift}), 4);
    checkOutput("puf_seed", int'(puf_seed), int'(s));
    if (start_len != done_delay) return;
    for (int b = 0; b < 32; b++) begin
      exp_q.push_back(src_bytes[b]);
      if (b == stall_byte) byte_ready = 1'b0;
      sh    = 0;
      guard = 0;
      while (!byte_valid && guard < 20) begin
        if (resp_shift) sh++;
        if (b == abort_byte && sh == 3) begin
          #2 rst = 1'b1;
          #1 v = {busy, puf_seed, puf_start, resp_shift, byte_data,
                  byte_valid, resp_done, timeout_err};
          checkOutput("async_reset_outputs", int'(v), 0);
          exp_q.delete();
          repeat (3) @(negedge clk);
          rst = 1'b0;
          return;
        end
        guard++;
        @(negedge clk);
      end
      checkOutput("shift_cycles", sh, 8);
      checkOutput("byte_valid_wait", int'(byte_valid), 1);
      if (!byte_valid) return;
      if (b == stall_byte) begin
        d0     = byte_data;
        stable = 0;
        for (int i = 0; i < 50; i++) begin
          if (byte_valid && byte_data == d0 && !resp_shift) stable++;
          @(negedge clk);
        end
        checkOutput("stall_stable", stable, 50);
        byte_ready = 1'b1;
      end
      extra = 0;
      @(negedge clk);
      while (byte_valid && extra < 100) begin
        extra++;
        @(negedge clk);
      end
      checkOutput("valid_after_handshake", extra, 0);
    end
    checkOutput("resp_done_pulse", int'({resp_done, busy}), 2);
    @(negedge clk);
    checkOutput("resp_done_count", tot_done - done_base, 1);
    checkOutput("total_shifts", tot_shift - shift_base, 256);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cnt, guard, tsh;
    bit err_seen;
    logic [21:0] v;
    rst = 1'b1; req = 1'b0; seed = 8'h00; puf_done = 1'b0; byte_ready = 1'b1;
    src_clr = 1'b0;
    t_req = 1'b0; t_seed = 8'h00; t_puf_done = 1'b0; t_byte_ready = 1'b1;
    t_resp_bit = 1'b1;
    src_bytes[0] = 8'hB2;
    for (int k = 1; k < 32; k++) src_bytes[k] = 8'hB2 + 8'(k * 29);

    repeat (3) @(negedge clk);
    v = {busy, puf_seed, puf_start, resp_shift, byte_data, byte_valid,
         resp_done, timeout_err};
    checkOutput("reset_outputs", int'(v), 0);
    checkOutput("reset_outputs_tmo", int'({t_busy, t_puf_start, t_timeout_err}), 0);

    $display("[TB] run 1: seed A5, done after 300 cycles, req held into RUN");
    applyStimulus(8'hA5, 300, -1, -1, 1'b1, 1'b1);
    $display("[TB] run 2: byte 3 stalled 50 cycles");
    applyStimulus(8'h5C, 20, 3, -1, 1'b0, 1'b0);
    $display("[TB] run 3: reset during byte 10");
    applyStimulus(8'h11, 20, -1, 10, 1'b0, 1'b0);
    $display("[TB] run 4: full run after reset");
    applyStimulus(8'hE7, 20, -1, -1, 1'b0, 1'b0);

    $display("[TB] timeout instance: no done");
    @(negedge clk);
    t_seed = 8'h5A;
    t_req  = 1'b1;
    @(negedge clk);
    cnt = 0;
    guard = 0;
    while (!t_timeout_err && guard < 40) begin
      if (t_puf_start) cnt++;
      guard++;
      @(negedge clk);
    end
    checkOutput("timeout_run_cycles", cnt, 15);
    checkOutput("err_state", int'({t_timeout_err, t_busy, t_puf_start}), 6);
    repeat (5) @(negedge clk);
    checkOutput("err_hold", int'(t_timeout_err), 1);
    t_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("err_exit", int'({t_timeout_err, t_busy}), 0);

    $display("[TB] timeout instance: done on final budget cycle");
    t_seed = 8'hC3;
    t_req  = 1'b1;
    @(negedge clk);
    t_req = 1'b0;
    cnt = 0;
    guard = 0;
    while (t_puf_start && guard < 40) begin
      cnt++;
      guard++;
      if (cnt == 15) begin
        t_puf_done = 1'b1;
        @(negedge clk);
        t_puf_done = 1'b0;
        break;
      end
      @(negedge clk);
    end
    checkOutput("done_at_limit", int'({t_timeout_err, t_busy, t_puf_start}), 2);
    checkOutput("t_puf_seed", int'(t_puf_seed), 8'hC3);
    err_seen = 1'b0;
    tsh = 0;
    guard = 0;
    while (!t_resp_done && guard < 100) begin
      if (t_byte_valid) checkOutput("t_byte_data", int'(t_byte_data), 8'hFF);
      if (t_timeout_err) err_seen = 1'b1;
      if (t_resp_shift) tsh++;
      guard++;
      @(negedge clk);
    end
    checkOutput("t_resp_done", int'(t_resp_done), 1);
    checkOutput("t_no_error", int'(err_seen), 0);
    checkOutput("t_shift_cycles", tsh, 16);

    repeat (2) @(negedge clk);
    checkOutput("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/puf_scheduler.md
PUF_SCHEDULER -- requirements
Module: puf_scheduler

Interface
REQ-001 SHALL have parameter NBYTES, default 32, meaning response bytes read per run (256 bits).
REQ-002 SHALL have parameter TIMEOUT, default 1048575, meaning maximum cycles to wait for puf_done; counter width 20 bits.
REQ-003 SHALL have port clk  in  1  single clock, all state changes on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req  in  1  host run request, level.
REQ-006 SHALL have port seed  in  8  challenge seed, captured when req is accepted.
REQ-007 SHALL have port busy  out  1  high in every state except IDLE.
REQ-008 SHALL have port puf_seed  out  8  registered seed driven to the LFSR.
REQ-009 SHALL have port puf_start  out  1  level start to the PUF control FSM.
REQ-010 SHALL have port puf_done  in  1  one-cycle completion pulse from the PUF control FSM.
REQ-011 SHALL have port resp_bit  in  1  current head bit of the response shift register.
REQ-012 SHALL have port resp_shift  out  1  shift enable to the response shift register.
REQ-013 SHALL have port byte_data  out  8  packed response byte.
REQ-014 SHALL have port byte_valid  out  1  byte_data valid.
REQ-015 SHALL have port byte_ready  in  1  downstream accepts byte.
REQ-016 SHALL have port resp_done  out  1  one-cycle pulse after last byte accepted.
REQ-017 SHALL have port timeout_err  out  1  high while in ERR.

Function
REQ-018 SHALL implement states IDLE, RUN, RELEASE, SHIFT, PRESENT, ERR.
REQ-019 IDLE: req=1 SHALL capture seed into puf_seed, clear timeout and byte counters, go RUN next cycle; req ignored in all other states.
REQ-020 RUN: puf_start SHALL be 1; timeout counter increments each cycle.
REQ-021 RUN: puf_done=1 SHALL go RELEASE; else counter == TIMEOUT-1 SHALL go ERR; puf_done wins if both in same cycle.
REQ-022 RELEASE: puf_start SHALL be 0 for exactly one cycle, then go SHIFT (lets the PUF control FSM return to idle).
REQ-023 SHIFT: resp_shift SHALL be 1 for exactly 8 consecutive cycles; each cycle byte register <= {byte[6:0], resp_bit} (first bit lands in MSB).
REQ-024 After the 8th shift SHALL go PRESENT with byte_valid=1 on the next cycle.
REQ-025 PRESENT: byte_data and byte_valid SHALL hold stable until byte_valid & byte_ready; resp_shift SHALL be 0.
REQ-026 On handshake with byte count < NBYTES-1: byte count +1, go SHIFT, byte_valid 0 next cycle.
REQ-027 On handshake with byte count == NBYTES-1: resp_done SHALL pulse 1 for one cycle, go IDLE.
REQ-028 byte_valid SHALL never drop without a handshake; byte_ready while byte_valid=0 SHALL be ignored.
REQ-029 ERR: timeout_err=1, puf_start=0; SHALL remain until req=0, then go IDLE.
REQ-030 Byte counter width SHALL be ceil(log2(NBYTES)) bits, no wrap within a run.
REQ-031 All outputs SHALL be registered; undefined state encodings SHALL go IDLE.

Reset
REQ-032 rst=1 SHALL immediately force state IDLE and zero every output (busy, puf_seed, puf_start, resp_shift, byte_data, byte_valid, resp_done, timeout_err) and all counters, including mid-run.
REQ-033 First req SHALL be accepted on the first clk edge after rst deasserts.

Verification
REQ-034 seed=0xA5, req pulse; puf_done after 300 cycles -> puf_seed=0xA5, puf_start high 300 cycles, 1 cycle low, then 8 resp_shift cycles.
REQ-035 resp_bit pattern 1,0,1,1,0,0,1,0 with byte_ready=1 -> byte_data=0xB2, byte_valid 1 cycle; 32 bytes total, resp_done one pulse, busy 0 after.
REQ-036 byte_ready held 0 for 50 cycles on byte 3 -> byte_valid/byte_data stable 50 cycles, no resp_shift, resume on ready.
REQ-037 TIMEOUT=15, no puf_done -> ERR after 15 RUN cycles, timeout_err=1 until req=0, then IDLE; puf_done and final count same cycle -> RELEASE, no error.
REQ-038 rst asserted mid-SHIFT of byte 10 -> all outputs 0 asynchronously; new req after release runs full 32 bytes.
